load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 50 +++++
 rtl/load_store_unit_align.sv | 49 ++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared constants for the load/store unit.
// Holds the cache size default, funct3 codes, op types, FSM states
// and the request legality check used at acceptance.
`ifndef _DATA_CACHE_SIZE
`define _DATA_CACHE_SIZE 4096
`endif

package load_store_unit_pkg;

    localparam int DATA_CACHE_SIZE = `_DATA_CACHE_SIZE;

    // RV32I width codes (loads and stores share B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_WAIT  = 3'd1,
        S_RMW_WAIT = 3'd2,
        S_WRITE    = 3'd3,
        S_RESP     = 3'd4
    } lsu_state_t;

    // Width/alignment legality; range is checked separately.
    // Unsigned codes have no store form, so they are illegal on stores.
    function automatic logic lsu_bad_code(
        input logic [2:0] f3,
        input logic       st,
        input logic [1:0] lo
    );
        logic w_bad;
        w_bad = 1'b1;
        unique case (1'b1)
            (f3 == F3_B):  w_bad = 1'b0;
            (f3 == F3_H):  w_bad = lo[0];
            (f3 == F3_W):  w_bad = (lo != 2'b00);
            (f3 == F3_BU): w_bad = st;
            (f3 == F3_HU): w_bad = st | lo[0];
            default:       w_bad = 1'b1;
        endcase
        return w_bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane select, load extension and store merge.
// Ports: i_funct3, i_offset (addr[1:0]), i_word (cache word), i_wdata
// (store data) -> o_load (extended load), o_store (merged write word).
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [4:0]  w_bpos;
    logic [4:0]  w_hpos;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bit offsets of the addressed byte and halfword lanes
    assign w_bpos = {i_offset, 3'b000};
    assign w_hpos = {i_offset[1], 4'b0000};
    assign w_byte = i_word[w_bpos +: 8];
    assign w_half = i_word[w_hpos +: 16];

    always_comb begin
        o_load = '0;
        unique case (1'b1)
            (i_funct3 == F3_B):  o_load = {{24{w_byte[7]}}, w_byte};
            (i_funct3 == F3_H):  o_load = {{16{w_half[15]}}, w_half};
            (i_funct3 == F3_W):  o_load = i_word;
            (i_funct3 == F3_BU): o_load = {24'd0, w_byte};
            (i_funct3 == F3_HU): o_load = {16'd0, w_half};
            default:             o_load = '0;
        endcase
    end

    // Only the addressed lanes take store data; the rest keep the old word
    always_comb begin
        o_store = i_word;
        unique case (1'b1)
            (i_funct3 == F3_B): o_store[w_bpos +: 8]  = i_wdata[7:0];
            (i_funct3 == F3_H): o_store[w_hpos +: 16] = i_wdata[15:0];
            (i_funct3 == F3_W): o_store = i_wdata;
            default:            o_store = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store FSM in front of a 1-cycle data cache.
// Ports: i_clk/i_rst, request (i_req_valid/o_req_ready, i_funct3,
// i_is_store, i_addr, i_wdata), response (o_resp_valid, o_rdata, o_err),
// cache (o_mem_address, o_mem_val, o_mem_op_type, i_mem_val).
`ifndef _DATA_CACHE_SIZE
`define _DATA_CACHE_SIZE 4096
`endif

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_LIMIT = `_DATA_CACHE_SIZE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_val,
    output logic        o_mem_op_type,
    input  logic [31:0] i_mem_val
);

    lsu_state_t  r_state;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_resp_valid;
    logic [31:0] r_mem_address;
    logic        r_mem_op;

    logic        w_accept;
    logic        w_bad;
    logic [31:0] w_load;
    logic [31:0] w_store;

    assign w_accept = i_req_valid && (r_state == S_IDLE);
    assign w_bad    = lsu_bad_code(i_funct3, i_is_store, i_addr[1:0])
                    || (i_addr >= 32'(ADDR_LIMIT));

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_offset (r_offset),
        .i_word   (i_mem_val),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_store  (w_store)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_funct3      <= '0;
            r_is_store    <= 1'b0;
            r_offset      <= '0;
            r_wdata       <= '0;
            r_err         <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_mem_address <= '0;
            r_mem_op      <= OP_READ;
        end else begin
            r_resp_valid <= 1'b0;
            r_mem_op     <= OP_READ;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= i_funct3;
                        r_is_store <= i_is_store;
                        r_offset   <= i_addr[1:0];
                        r_wdata    <= i_wdata;
                        r_err      <= w_bad;
                        if (w_bad) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_mem_address <= {i_addr[31:2], 2'b00};
                            if (!i_is_store) begin
                                r_state <= S_LD_WAIT;
                            end else if (i_funct3 == F3_W) begin
                                r_state  <= S_WRITE;
                                r_mem_op <= OP_WRITE;
                            end else begin
                                r_state <= S_RMW_WAIT;
                            end
                        end
                    end
                end
                S_LD_WAIT: begin
                    r_state       <= S_RESP;
                    r_resp_valid  <= 1'b1;
                    r_mem_address <= '0;
                end
                S_RMW_WAIT: begin
                    r_state  <= S_WRITE;
                    r_mem_op <= OP_WRITE;
                end
                S_WRITE: begin
                    r_state       <= S_RESP;
                    r_resp_valid  <= 1'b1;
                    r_mem_address <= '0;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Cache read data only arrives in RESP (loads) or WRITE (RMW), so
    // the load result and the merged write word are formed from i_mem_val
    // in those states rather than registered.
    assign o_rdata = (r_state == S_RESP && !r_is_store && !r_err)
                   ? w_load : '0;
    assign o_mem_val = (r_state == S_WRITE) ? w_store : '0;

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_resp_valid  = r_resp_valid;
    assign o_err         = r_err;
    assign o_mem_address = r_mem_address;
    assign o_mem_op_type = r_mem_op;

endmodule
